ps2_key_decoder: RTL

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises the raw lines, samples them on a divided
// tick, assembles 11-bit frames, strips E0/F0 prefixes and queues key events.
// Optional macro PS2_KEYMAP_EN adds a held-key bitmap for 17 tracked scan codes.
module ps2_key_decoder #(
    parameter int unsigned SAMPLE_DIV = 250,
    parameter int unsigned TIMEOUT    = 4000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        PS2_KBCLK,
    input  logic        PS2_KBDAT,
    output logic        EVT_VALID,
    input  logic        EVT_READY,
    output logic [7:0]  EVT_CODE,
    output logic        EVT_EXT,
    output logic        EVT_BREAK,
    output logic [16:0] KEY_DOWN,
    output logic        ERR_PULSE,
    output logic        OVERFLOW
);

    localparam int unsigned DIV_W = 16;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic             dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic             clk_prev_q, clk_prev_d;
    logic [10:0]      shift_q, shift_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             done_q, done_d;
    logic [10:0]      frame_q, frame_d;
    logic [1:0]       state_q, state_d;
    logic             err_q, err_d;
    logic [9:0]       mem_q [FIFO_DEPTH];
    logic [9:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             fall_c, good_c, push_c, pop_c, full_c, wr_ok_c;
    logic [7:0]       byte_c;
    logic [9:0]       push_ev_c;

    // Sample tick divider and two-flop line synchronisers
    always_comb begin
        div_d    = div_q + DIV_W'(1);
        tick_d   = 1'b0;
        if (div_q == DIV_W'(SAMPLE_DIV - 1)) begin
            div_d  = '0;
            tick_d = 1'b1;
        end
        clk_s1_d = PS2_KBCLK;
        clk_s2_d = clk_s1_q;
        dat_s1_d = PS2_KBDAT;
        dat_s2_d = dat_s1_q;
    end

    // Frame assembly on sampled falling edges, with per-frame tick timeout
    always_comb begin
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        to_cnt_d   = to_cnt_q;
        clk_prev_d = clk_prev_q;
        done_d     = 1'b0;
        frame_d    = frame_q;
        fall_c     = clk_prev_q & ~clk_s2_q;
        if (tick_q) begin
            clk_prev_d = clk_s2_q;
            if ((bit_cnt_q != 4'd0) && (to_cnt_q == TO_W'(TIMEOUT - 1))) begin
                bit_cnt_d = 4'd0;
                to_cnt_d  = '0;
            end else begin
                if (bit_cnt_q != 4'd0) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
                if (fall_c) begin
                    shift_d = {dat_s2_q, shift_q[10:1]};
                    if (bit_cnt_q == 4'd0) begin
                        to_cnt_d = '0;
                    end
                    if (bit_cnt_q == 4'd10) begin
                        bit_cnt_d = 4'd0;
                        done_d    = 1'b1;
                        frame_d   = {dat_s2_q, shift_q[10:1]};
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
        end
    end

    // Frame check and E0/F0 prefix FSM; ordinary bytes become events
    always_comb begin
        state_d   = state_q;
        err_d     = 1'b0;
        push_c    = 1'b0;
        byte_c    = frame_q[8:1];
        good_c    = ~frame_q[0] & frame_q[10] & (^frame_q[9:1]);
        push_ev_c = {(state_q == ST_EXT) || (state_q == ST_EXT_BRK),
                     (state_q == ST_BRK) || (state_q == ST_EXT_BRK),
                     byte_c};
        if (done_q) begin
            if (!good_c) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end else if (byte_c == 8'hE0) begin
                if (state_q == ST_IDLE) state_d = ST_EXT;
            end else if (byte_c == 8'hF0) begin
                if (state_q == ST_IDLE)     state_d = ST_BRK;
                else if (state_q == ST_EXT) state_d = ST_EXT_BRK;
            end else begin
                push_c  = 1'b1;
                state_d = ST_IDLE;
            end
        end
    end

    // Event FIFO; a full FIFO accepts a push only when it also pops
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        full_c   = (count_q == CNT_W'(FIFO_DEPTH));
        pop_c    = (count_q != '0) & EVT_READY;
        wr_ok_c  = push_c & (~full_c | pop_c);
        if (wr_ok_c) begin
            mem_d[wr_ptr_q] = push_ev_c;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_c && !wr_ok_c) begin
            ovf_d = 1'b1;
        end
        count_d = count_q + CNT_W'(wr_ok_c) - CNT_W'(pop_c);
    end

    // State registers
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            div_q      <= '0;
            tick_q     <= 1'b0;
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            to_cnt_q   <= '0;
            done_q     <= 1'b0;
            frame_q    <= '0;
            state_q    <= ST_IDLE;
            err_q      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            div_q      <= div_d;
            tick_q     <= tick_d;
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            dat_s1_q   <= dat_s1_d;
            dat_s2_q   <= dat_s2_d;
            clk_prev_q <= clk_prev_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            to_cnt_q   <= to_cnt_d;
            done_q     <= done_d;
            frame_q    <= frame_d;
            state_q    <= state_d;
            err_q      <= err_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef PS2_KEYMAP_EN
    localparam logic [7:0] KEY_CODES [17] = '{
        8'h75, 8'h72, 8'h6B, 8'h74, 8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h35,
        8'h34, 8'h33, 8'h3B, 8'h4D, 8'h4B, 8'h4C, 8'h52, 8'h29};

    logic [16:0] key_q, key_d;

    // Held-key bitmap follows make/break of tracked codes, ignoring EXT
    always_comb begin
        key_d = key_q;
        if (push_c) begin
            for (int i = 0; i < 17; i++) begin
                if (push_ev_c[7:0] == KEY_CODES[i]) key_d[i] = ~push_ev_c[8];
            end
        end
    end

    // Held-key register
    always_ff @(posedge CLOCK_50) begin
        if (RESET) key_q <= '0;
        else       key_q <= key_d;
    end

    assign KEY_DOWN = key_q;
`else
    assign KEY_DOWN = '0;
`endif

    assign EVT_VALID = (count_q != '0);
    assign EVT_EXT   = mem_q[rd_ptr_q][9];
    assign EVT_BREAK = mem_q[rd_ptr_q][8];
    assign EVT_CODE  = mem_q[rd_ptr_q][7:0];
    assign ERR_PULSE = err_q;
    assign OVERFLOW  = ovf_q;

endmodule
